// File: rtl/biu_pkg.sv
// Shared types and constants for the BIU AHB arbiter: state encoding, size codes,
// default widths and the load/store strobe decode.
package biu_pkg;

    localparam int BIU_ADDR_W = 34;
    localparam int BIU_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GNT_IF = 2'b01,
        ST_GNT_LS = 2'b10,
        ST_RESP   = 2'b11
    } arb_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Strobe vector order: {r32, r16, r8, w32, w16, w8}
    typedef logic [5:0] strobe_t;

    localparam strobe_t IF_STROBE = 6'b100000;

    function automatic strobe_t ls_strobe(input logic we, input logic [1:0] size);
        strobe_t s;
        case (size)
            SZ_B:    s = we ? 6'b000001 : 6'b001000;
            SZ_H:    s = we ? 6'b000010 : 6'b010000;
            default: s = we ? 6'b000100 : 6'b100000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/biu_arb_watchdog.sv
// Bus-hang watchdog: counts consecutive grant cycles and flags the cycle in which
// the grant reaches TIMEOUT_CYC without completion. TIMEOUT_CYC = 0 disables it.
module biu_arb_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

            logic [CNT_W-1:0] cnt_r;

            // Grant-cycle counter; any cycle outside a grant clears it
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (active) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            end

            // cnt_r holds the number of grant cycles already completed
            assign expired = active && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/biu_ahb_arbiter.sv
// Arbitrates the BIU's single AHB master port between fetch (IF) and load/store (LS).
// Define BIU_ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module biu_ahb_arbiter
    import biu_pkg::*;
#(
    parameter int ADDR_W      = BIU_ADDR_W,
    parameter int DATA_W      = BIU_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic              if_fault,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic              ls_fault,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              m_r32,
    output logic              m_r16,
    output logic              m_r8,
    output logic              m_w32,
    output logic              m_w16,
    output logic              m_w8,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rdy,
    input  logic              m_fault,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    arb_state_e        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    strobe_t           strb_r;
    logic              if_done_r;
    logic              if_fault_r;
    logic              ls_done_r;
    logic              ls_fault_r;
    logic              busy_r;
`ifdef BIU_ARB_RR_EN
    logic              last_ls_r;
`endif

    logic              pick_ls_s;
    logic              grant_s;
    logic              expired_s;
    logic              xfer_end_s;
    logic              xfer_fault_s;
    logic [DATA_W-1:0] xfer_rdata_s;

    biu_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (grant_s),
        .expired (expired_s)
    );

    // Arbitration winner evaluated in the IDLE cycle
    always_comb begin
        pick_ls_s = 1'b0;
`ifdef BIU_ARB_RR_EN
        if (ls_req && if_req) begin
            pick_ls_s = !last_ls_r;
        end else begin
            pick_ls_s = ls_req;
        end
`else
        pick_ls_s = ls_req;
`endif
    end

    // Grant decode and transfer-completion qualification; m_fault dominates m_rdy
    always_comb begin
        grant_s      = (state_r == ST_GNT_IF) || (state_r == ST_GNT_LS);
        xfer_end_s   = m_rdy || m_fault || expired_s;
        xfer_fault_s = m_fault || !m_rdy;
        xfer_rdata_s = (m_rdy || m_fault) ? m_rdata : {DATA_W{1'b0}};
    end

    // Arbiter FSM with registered strobes, address, data and responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            rdata_r    <= {DATA_W{1'b0}};
            strb_r     <= 6'b000000;
            if_done_r  <= 1'b0;
            if_fault_r <= 1'b0;
            ls_done_r  <= 1'b0;
            ls_fault_r <= 1'b0;
            busy_r     <= 1'b0;
`ifdef BIU_ARB_RR_EN
            last_ls_r  <= 1'b0;
`endif
        end else begin
            if_done_r  <= 1'b0;
            if_fault_r <= 1'b0;
            ls_done_r  <= 1'b0;
            ls_fault_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ls_req || if_req) begin
                        busy_r <= 1'b1;
`ifdef BIU_ARB_RR_EN
                        last_ls_r <= pick_ls_s;
`endif
                        if (pick_ls_s) begin
                            addr_r  <= ls_addr;
                            wdata_r <= ls_wdata;
                            strb_r  <= ls_strobe(ls_we, ls_size);
                            state_r <= ST_GNT_LS;
                        end else begin
                            addr_r  <= if_addr;
                            wdata_r <= {DATA_W{1'b0}};
                            strb_r  <= IF_STROBE;
                            state_r <= ST_GNT_IF;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GNT_IF, ST_GNT_LS: begin
                    // Strobes stay up through the completing cycle and drop right after
                    if (xfer_end_s) begin
                        state_r    <= ST_RESP;
                        strb_r     <= 6'b000000;
                        busy_r     <= 1'b0;
                        rdata_r    <= xfer_rdata_s;
                        if_done_r  <= (state_r == ST_GNT_IF);
                        if_fault_r <= (state_r == ST_GNT_IF) && xfer_fault_s;
                        ls_done_r  <= (state_r == ST_GNT_LS);
                        ls_fault_r <= (state_r == ST_GNT_LS) && xfer_fault_s;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    strb_r  <= 6'b000000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign {m_r32, m_r16, m_r8, m_w32, m_w16, m_w8} = strb_r;
    assign m_addr   = addr_r;
    assign m_wdata  = wdata_r;
    assign busy     = busy_r;
    assign if_done  = if_done_r;
    assign if_fault = if_fault_r;
    assign if_rdata = rdata_r;
    assign ls_done  = ls_done_r;
    assign ls_fault = ls_fault_r;
    assign ls_rdata = rdata_r;

endmodule
